led_frame_scheduler: RTL and testbench

- Controller in front of the 16x16 LED column-scan driver.
- Owns a double-buffered 256-bit frame. Two writers (note-lane renderer A, score/overlay renderer B) share the back buffer under round-robin arbitration.
- Generates the column-advance tick and blanking window that pace the scan.
- Swaps back to front only at a scan-cycle boundary, so a displayed frame never tears.

---
 rtl/led_frame_scheduler.sv | 142 ++++++++++++++
 tb/tb_led_frame_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_scheduler.sv
// Double-buffered 16x16 LED frame controller: column-scan pacing, blanking,
// round-robin back-buffer writers and tear-free swap at the scan wrap.
module led_frame_scheduler #(
   parameter int unsigned DWELL = 1000,
   parameter int unsigned BLANK = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a_valid,
   input  logic [3:0]   a_col,
   input  logic [15:0]  a_data,
   output logic         a_ready,
   input  logic         b_valid,
   input  logic [3:0]   b_col,
   input  logic [15:0]  b_data,
   output logic         b_ready,
   input  logic         clr,
   input  logic         swap_req,
   output logic         swap_ack,
   output logic         swap_pending,
   output logic [255:0] frame_out,
   output logic         scan_tick,
   output logic [3:0]   col_idx,
   output logic         blank,
   output logic [7:0]   frame_cnt
);

   localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
   localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

   typedef enum logic {GRANT_A, GRANT_B} grant_e;

   logic [15:0] cnt_q, cnt_d;
   logic        scan_tick_q;
   logic [3:0]  col_idx_q, col_idx_d;
   logic        blank_q, blank_d;
   logic [15:0] blank_rem_q, blank_rem_d;
   logic        swap_pending_q, swap_pending_d;
   logic        swap_ack_q;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   grant_e      last_grant_q, last_grant_d;

   logic        tick_now;
   logic        swap_fire;
   logic        wr_en;
   logic [3:0]  wr_col;
   logic [15:0] wr_data;

   assign tick_now  = (cnt_q == DWELL_LAST);
   // Swap only on the tick that rolls the display from column 15 back to 0.
   assign swap_fire = tick_now && (col_idx_q == 4'd15) && (swap_pending_q || swap_req);

   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (!clr && !swap_pending_q) begin
         if (a_valid && b_valid) begin
            a_ready = (last_grant_q == GRANT_B);
            b_ready = (last_grant_q == GRANT_A);
         end else begin
            a_ready = a_valid;
            b_ready = b_valid;
         end
      end
   end

   assign wr_en   = a_ready || b_ready;
   assign wr_col  = a_ready ? a_col  : b_col;
   assign wr_data = a_ready ? a_data : b_data;

   always_comb begin
      cnt_d          = tick_now ? 16'd0 : cnt_q + 16'd1;
      col_idx_d      = tick_now ? col_idx_q + 4'd1 : col_idx_q;
      blank_d        = 1'b0;
      blank_rem_d    = blank_rem_q;
      if (tick_now) begin
         blank_d     = 1'b1;
         blank_rem_d = BLANK_LAST;
      end else if (blank_rem_q != 16'd0) begin
         blank_d     = 1'b1;
         blank_rem_d = blank_rem_q - 16'd1;
      end
      swap_pending_d = swap_fire ? 1'b0 : (swap_pending_q || swap_req);
      frame_cnt_d    = frame_cnt_q + 8'(swap_fire);
      last_grant_d   = last_grant_q;
      if (a_ready)      last_grant_d = GRANT_A;
      else if (b_ready) last_grant_d = GRANT_B;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q          <= 16'd0;
         scan_tick_q    <= 1'b0;
         col_idx_q      <= 4'd0;
         blank_q        <= 1'b1;
         blank_rem_q    <= BLANK_LAST;
         swap_pending_q <= 1'b0;
         swap_ack_q     <= 1'b0;
         frame_cnt_q    <= 8'd0;
         last_grant_q   <= GRANT_B;
      end else begin
         cnt_q          <= cnt_d;
         scan_tick_q    <= tick_now;
         col_idx_q      <= col_idx_d;
         blank_q        <= blank_d;
         blank_rem_q    <= blank_rem_d;
         swap_pending_q <= swap_pending_d;
         swap_ack_q     <= swap_fire;
         frame_cnt_q    <= frame_cnt_d;
         last_grant_q   <= last_grant_d;
      end
   end

   // One back/front column pair per generate instance; clear beats any write.
   for (genvar gi = 0; gi < 16; gi++) begin : g_col
      logic [15:0] back_q;
      logic [15:0] front_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            back_q  <= 16'd0;
            front_q <= 16'd0;
         end else begin
            if (swap_fire) front_q <= back_q;
            if (clr)
               back_q <= 16'd0;
            else if (wr_en && (wr_col == 4'(gi)))
               back_q <= wr_data;
         end
      end

      assign frame_out[gi*16 +: 16] = front_q;
   end

   assign scan_tick    = scan_tick_q;
   assign col_idx      = col_idx_q;
   assign blank        = blank_q;
   assign swap_ack     = swap_ack_q;
   assign swap_pending = swap_pending_q;
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Randomised + directed bench for led_frame_scheduler against a cycle-count
// based behavioural model of scan timing, arbitration and swapping.
module tb_led_frame_scheduler;

   localparam int unsigned DWELL = 4;
   localparam int unsigned BLANK = 1;
   localparam int unsigned SCAN  = 16 * DWELL;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         a_valid = 1'b0, b_valid = 1'b0, clr = 1'b0, swap_req = 1'b0;
   logic [3:0]   a_col = 4'd0, b_col = 4'd0;
   logic [15:0]  a_data = 16'd0, b_data = 16'd0;
   logic         a_ready, b_ready, swap_ack, swap_pending, scan_tick, blank;
   logic [255:0] frame_out;
   logic [3:0]   col_idx;
   logic [7:0]   frame_cnt;

   led_frame_scheduler #(.DWELL(DWELL), .BLANK(BLANK)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_col(a_col), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_col(b_col), .b_data(b_data), .b_ready(b_ready),
      .clr(clr), .swap_req(swap_req), .swap_ack(swap_ack), .swap_pending(swap_pending),
      .frame_out(frame_out), .scan_tick(scan_tick), .col_idx(col_idx),
      .blank(blank), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: everything derives from the edge count since reset release.
   int unsigned mn;
   logic [15:0] mback [16];
   logic [15:0] mfront[16];
   logic        mpending, mack, mlast_b;
   logic [7:0]  mcnt;

   function automatic logic [1:0] exp_ready(input logic av, input logic bv,
                                            input logic cl, input logic pend,
                                            input logic lastb);
      if (cl || pend) return 2'b00;
      if (av && bv)   return lastb ? 2'b01 : 2'b10;
      return {bv, av};
   endfunction

   task automatic model_reset();
      mn = 0; mpending = 1'b0; mack = 1'b0; mlast_b = 1'b1; mcnt = 8'd0;
      for (int c = 0; c < 16; c++) begin
         mback[c] = 16'd0;
         mfront[c] = 16'd0;
      end
   endtask

   task automatic model_step();
      logic [1:0]  g;
      int unsigned nn;
      logic        fire;
      g    = exp_ready(a_valid, b_valid, clr, mpending, mlast_b);
      nn   = mn + 1;
      fire = ((nn % SCAN) == 0) && (mpending || swap_req);
      if (fire) begin
         for (int c = 0; c < 16; c++) mfront[c] = mback[c];
         mcnt     = mcnt + 8'd1;
         mpending = 1'b0;
         mack     = 1'b1;
      end else begin
         mack = 1'b0;
         if (swap_req) mpending = 1'b1;
      end
      if (clr) begin
         for (int c = 0; c < 16; c++) mback[c] = 16'd0;
      end else if (g[0]) begin
         mback[a_col] = a_data;
      end else if (g[1]) begin
         mback[b_col] = b_data;
      end
      if (g[0])      mlast_b = 1'b0;
      else if (g[1]) mlast_b = 1'b1;
      mn = nn;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else      model_step();
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      logic [255:0] ef;
      logic [1:0]   er;
      forever begin
         @(negedge clk);
         for (int c = 0; c < 16; c++) ef[c*16 +: 16] = mfront[c];
         er = exp_ready(a_valid, b_valid, clr, mpending, mlast_b);
         chk("frame_out",    frame_out, ef);
         chk("scan_tick",    256'(scan_tick),    256'((mn > 0) && ((mn % DWELL) == 0)));
         chk("col_idx",      256'(col_idx),      256'((mn / DWELL) % 16));
         chk("blank",        256'(blank),        256'((mn % DWELL) < BLANK));
         chk("swap_ack",     256'(swap_ack),     256'(mack));
         chk("swap_pending", 256'(swap_pending), 256'(mpending));
         chk("frame_cnt",    256'(frame_cnt),    256'(mcnt));
         chk("a_ready",      256'(a_ready),      256'(er[0]));
         chk("b_ready",      256'(b_ready),      256'(er[1]));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input string name);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (swap_ack) break;
      end
      chk(name, 256'(swap_ack), 256'(1));
   endtask

   logic [255:0] lit;

   initial begin
      // Reset and scan timing
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("lit_reset_blank",    256'(blank),     256'(1));
      chk("lit_reset_col",      256'(col_idx),   256'(0));
      chk("lit_reset_cnt",      256'(frame_cnt), 256'(0));
      chk("lit_reset_frame",    frame_out,       256'(0));
      chk("lit_reset_pending",  256'(swap_pending), 256'(0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("lit_no_tick_at_3",   256'(scan_tick), 256'(0));
      @(posedge clk);
      @(negedge clk);
      chk("lit_first_tick",     256'(scan_tick), 256'(1));
      chk("lit_first_col",      256'(col_idx),   256'(1));

      // Single writer
      cyc();
      a_valid = 1'b1; a_col = 4'd3; a_data = 16'hA5A5;
      @(negedge clk);
      chk("lit_single_ready", 256'(a_ready), 256'(1));
      cyc();
      a_valid = 1'b0; swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      @(negedge clk);
      chk("lit_single_pre_swap", 256'(frame_out[63:48]), 256'(0));
      wait_ack("single_ack_timeout");
      chk("lit_single_frame", 256'(frame_out[63:48]), 256'(16'hA5A5));
      chk("lit_single_cnt",   256'(frame_cnt), 256'(1));
      chk("lit_single_col0",  256'(col_idx),   256'(0));
      cyc();
      @(negedge clk);
      chk("lit_ack_one_cycle", 256'(swap_ack), 256'(0));

      // Reset mid-write with a pending swap discards everything
      cyc();
      swap_req = 1'b1; a_valid = 1'b1; a_col = 4'd5; a_data = 16'h5555;
      cyc();
      swap_req = 1'b0; a_valid = 1'b0;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("lit_midreset_frame",   frame_out, 256'(0));
      chk("lit_midreset_pending", 256'(swap_pending), 256'(0));
      chk("lit_midreset_cnt",     256'(frame_cnt), 256'(0));
      cyc();
      rst = 1'b1;

      // Contention: A,B,A,B from reset
      for (int k = 0; k < 4; k++) begin
         a_valid = 1'b1; a_col = 4'(k);     a_data = 16'hA000 + 16'(k);
         b_valid = 1'b1; b_col = 4'(k + 8); b_data = 16'hB000 + 16'(k);
         @(negedge clk);
         chk("lit_contend_a", 256'(a_ready), 256'((k % 2) == 0));
         chk("lit_contend_b", 256'(b_ready), 256'((k % 2) == 1));
         cyc();
      end
      a_valid = 1'b0; b_valid = 1'b0; swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      wait_ack("contend_ack_timeout");
      lit = '0;
      lit[0*16 +: 16]  = 16'hA000;
      lit[9*16 +: 16]  = 16'hB001;
      lit[2*16 +: 16]  = 16'hA002;
      lit[11*16 +: 16] = 16'hB003;
      chk("lit_contend_frame", frame_out, lit);
      chk("lit_contend_cnt",   256'(frame_cnt), 256'(1));

      // Tear guard: request at column 5, writer blocked until the swap
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (col_idx == 4'd5) break;
      end
      chk("col5_reached", 256'(col_idx), 256'(5));
      cyc();
      swap_req = 1'b1;
      cyc();
      swap_req = 1'b0; a_valid = 1'b1; a_col = 4'd7; a_data = 16'h7777;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (swap_ack) break;
         chk("lit_tear_blocked", 256'(a_ready), 256'(0));
         chk("lit_tear_front",   frame_out, lit);
      end
      chk("tear_ack_seen",    256'(swap_ack), 256'(1));
      chk("lit_tear_swapped", frame_out, lit);
      chk("lit_tear_release", 256'(a_ready), 256'(1));
      cyc();
      a_valid = 1'b0; swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      wait_ack("tear_ack2_timeout");
      chk("lit_tear_landed", 256'(frame_out[127:112]), 256'(16'h7777));

      // Clear priority over a same-cycle write
      cyc();
      clr = 1'b1; a_valid = 1'b1; a_col = 4'd1; a_data = 16'h1234;
      @(negedge clk);
      chk("lit_clr_blocks", 256'(a_ready), 256'(0));
      cyc();
      clr = 1'b0; a_valid = 1'b0; swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      wait_ack("clr_ack_timeout");
      chk("lit_clr_frame", frame_out, 256'(0));

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         cyc();
         a_valid  = 1'($urandom_range(0, 1));
         b_valid  = 1'($urandom_range(0, 1));
         a_col    = 4'($urandom_range(0, 15));
         b_col    = 4'($urandom_range(0, 15));
         a_data   = 16'($urandom);
         b_data   = 16'($urandom);
         clr      = ($urandom_range(0, 15) == 0);
         swap_req = ($urandom_range(0, 19) == 0);
      end
      cyc();
      a_valid = 1'b0; b_valid = 1'b0; clr = 1'b0; swap_req = 1'b0;

      // frame_cnt wrap with swap_req only in the wrap-tick cycle
      cyc();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      for (int s = 0; s < 256; s++) begin
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (scan_tick && col_idx == 4'd15) break;
         end
         chk("col15_tick_seen", 256'(scan_tick && col_idx == 4'd15), 256'(1));
         cyc();
         cyc();
         cyc();
         swap_req = 1'b1;
         cyc();
         swap_req = 1'b0;
         @(negedge clk);
         chk("lit_wrap_tick_ack", 256'(swap_ack), 256'(1));
         if (s == 0) chk("lit_wrap_first_cnt", 256'(frame_cnt), 256'(1));
      end
      chk("lit_frame_cnt_wrap", 256'(frame_cnt), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
